// File: rtl/bus_demux_reg16.sv
// rtl/bus_demux_reg16.sv - 16-entry register bank write port with per-register valid flags
module bus_demux_reg16 #(
    parameter int WIDTH    = 64,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   clr_valid,
    output logic [15:0][WIDTH-1:0] regs,
    output logic [15:0]            valid,
    output logic                   wr_ack
);

    logic             accept;
    logic             wr_ack_q;
    logic [WIDTH-1:0] data_w [16];
    logic             valid_w [16];

    // A write to the hardwired zero register is dropped and never acknowledged.
    assign accept = wr_en && !(ZERO_REG && (wr_addr == 4'd15));

    for (genvar i = 0; i < 16; i++) begin : g_reg
        if ((i == 15) && ZERO_REG) begin : g_zero
            assign data_w[i]  = '0;
            assign valid_w[i] = 1'b1;
        end else begin : g_flop
            logic             we;
            logic [WIDTH-1:0] data_q, data_d;
            logic             valid_q, valid_d;

            assign we = accept && (wr_addr == 4'(i));

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (clr_valid) valid_d = 1'b0;
                if (we) begin
                    data_d  = wr_data;
                    valid_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign data_w[i]  = data_q;
            assign valid_w[i] = valid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_ack_q <= 1'b0;
        else       wr_ack_q <= accept;
    end

    always_comb begin
        regs  = '0;
        valid = '0;
        for (int i = 0; i < 16; i++) begin
            regs[i]  = data_w[i];
            valid[i] = valid_w[i];
        end
    end

    assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_bus_demux_reg16.sv
// tb/tb_bus_demux_reg16.sv - randomized model-checked bench for bus_demux_reg16
module tb_bus_demux_reg16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_addr = '0;
    logic [7:0]      wr_data = '0;
    logic            clr_valid = 1'b0;
    logic [15:0][7:0] regs_z, regs_n;
    logic [15:0]     valid_z, valid_n;
    logic            ack_z, ack_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0 has the hardwired zero register, instance 1 does not.
    bus_demux_reg16 #(.WIDTH(8), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_valid(clr_valid), .regs(regs_z), .valid(valid_z), .wr_ack(ack_z));

    bus_demux_reg16 #(.WIDTH(8), .ZERO_REG(1'b0)) dut_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_valid(clr_valid), .regs(regs_n), .valid(valid_n), .wr_ack(ack_n));

    always #5 clk = ~clk;

    logic [3:0] mux_sel = '0;
    logic [7:0] mux_out;
    assign mux_out = regs_z[mux_sel];

    logic [7:0]  m_regs [2][16];
    logic [15:0] m_valid [2];
    logic        m_ack [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) m_regs[k][i] = 8'h00;
            m_valid[k] = (k == 0) ? 16'h8000 : 16'h0000;
            m_ack[k]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit ok;
            ok = wr_en && !(k == 0 && wr_addr == 4'd15);
            if (clr_valid) m_valid[k] = (k == 0) ? 16'h8000 : 16'h0000;
            if (ok) begin
                m_regs[k][wr_addr]  = wr_data;
                m_valid[k][wr_addr] = 1'b1;
            end
            m_ack[k] = ok;
        end
    endtask

    task automatic compare_all(input string ph);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("%s z.regs[%0d]", ph, i), 64'(regs_z[i]), 64'(m_regs[0][i]));
            check_eq($sformatf("%s n.regs[%0d]", ph, i), 64'(regs_n[i]), 64'(m_regs[1][i]));
        end
        check_eq({ph, " z.valid"}, 64'(valid_z), 64'(m_valid[0]));
        check_eq({ph, " n.valid"}, 64'(valid_n), 64'(m_valid[1]));
        check_eq({ph, " z.wr_ack"}, 64'(ack_z), 64'(m_ack[0]));
        check_eq({ph, " n.wr_ack"}, 64'(ack_n), 64'(m_ack[1]));
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        compare_all(ph);
    endtask

    task automatic drive(input logic en, input logic [3:0] a, input logic [7:0] d, input logic clr);
        wr_en = en; wr_addr = a; wr_data = d; clr_valid = clr;
    endtask

    logic [7:0] wrote [16];

    initial begin
        // Asynchronous reset between edges.
        #3 reset = 1'b1;
        #1 model_reset();
        compare_all("async_reset");
        check_eq("reset valid_z", 64'(valid_z), 64'h8000);
        @(posedge clk); #1;
        compare_all("reset_held");
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 4'(i), 8'hA0 + 8'(i), 1'b0);
            cycle("sweep");
            check_eq("sweep reg", 64'(regs_z[i]), 64'(8'hA0 + 8'(i)));
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        cycle("idle");
        check_eq("sweep end valid", 64'(valid_z), 64'hFFFF);
        check_eq("ack drops", 64'(ack_z), 64'h0);

        drive(1'b1, 4'd15, 8'hFF, 1'b0);
        cycle("wr15");
        check_eq("wr15 z.reg", 64'(regs_z[15]), 64'h00);
        check_eq("wr15 z.ack", 64'(ack_z), 64'h0);
        check_eq("wr15 n.reg", 64'(regs_n[15]), 64'hFF);
        check_eq("wr15 n.ack", 64'(ack_n), 64'h1);

        drive(1'b1, 4'd3, 8'h5C, 1'b1);
        cycle("clr_wr");
        check_eq("clr_wr valid", 64'(valid_z), 64'h8008);
        check_eq("clr_wr reg3", 64'(regs_z[3]), 64'h5C);
        check_eq("clr_wr reg0", 64'(regs_z[0]), 64'hA0);
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        cycle("post_clr");

        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                  1'($urandom_range(0, 15) == 0));
            cycle("random");
        end

        // Reset raised in the same cycle as a write.
        drive(1'b1, 4'd2, 8'h11, 1'b0);
        #2 reset = 1'b1;
        #1 model_reset();
        compare_all("mid_reset");
        cycle("mid_reset_edge");
        check_eq("mid_reset reg2", 64'(regs_z[2]), 64'h00);
        @(negedge clk) reset = 1'b0;
        drive(1'b1, 4'd2, 8'h22, 1'b0);
        cycle("after_reset");
        check_eq("after_reset reg2", 64'(regs_z[2]), 64'h22);

        for (int i = 0; i < 16; i++) begin
            wrote[i] = 8'h40 + 8'(i * 7);
            drive(1'b1, 4'(i), wrote[i], 1'b0);
            cycle("e2e_wr");
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        cycle("e2e_idle");
        for (int s = 0; s < 16; s++) begin
            mux_sel = 4'(s);
            #1;
            check_eq($sformatf("mux sel %0d", s), 64'(mux_out), (s == 15) ? 64'h0 : 64'(wrote[s]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
